// File: rtl/uart_rx_core.sv
// UART receiver: oversampled by s_tick, configurable data width, parity and stop bits,
// delivering each frame on a one-entry valid/ready output register with error flags.
module uart_rx_core #(
  parameter int D_W       = 8,
  parameter int B_TICK    = 16,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s_tick,
  input  logic           rxd,
  output logic [D_W-1:0] out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           parity_err,
  output logic           framing_err,
  output logic           overrun,
  output logic           busy
);

  localparam int TW = $clog2(B_TICK);
  localparam int BW = $clog2(D_W + 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(B_TICK / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(B_TICK - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(D_W - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT_IDLE
  } state_t;

  state_t         state, state_n;
  logic [TW-1:0]  tick_cnt, tick_n;
  logic [BW-1:0]  bit_cnt, bit_n;
  logic [D_W-1:0] shreg, shreg_n;
  logic           par_err_q, par_err_n;
  logic           frm_err_q, frm_err_n;
  logic           rxd_meta, rxd_s;
  logic           frame_done, frame_fe, stop_fe, par_x;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  assign par_x   = ^{shreg, rxd_s};
  assign stop_fe = frm_err_q | ~rxd_s;
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      state     <= state_n;
      tick_cnt  <= tick_n;
      bit_cnt   <= bit_n;
      shreg     <= shreg_n;
      par_err_q <= par_err_n;
      frm_err_q <= frm_err_n;
    end
  end

  always_comb begin
    state_n    = state;
    tick_n     = tick_cnt;
    bit_n      = bit_cnt;
    shreg_n    = shreg;
    par_err_n  = par_err_q;
    frm_err_n  = frm_err_q;
    frame_done = 1'b0;
    frame_fe   = frm_err_q;
    case (state)
      S_IDLE: begin
        if (!rxd_s) begin
          state_n = S_START;
          tick_n  = '0;
        end
      end
      // Start bit is re-checked at its midpoint so short low glitches are ignored.
      S_START: begin
        if (s_tick) begin
          if (tick_cnt == TICK_MID) begin
            tick_n = '0;
            if (!rxd_s) begin
              state_n   = S_DATA;
              bit_n     = '0;
              par_err_n = 1'b0;
              frm_err_n = 1'b0;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end
      end
      S_DATA: begin
        if (s_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_n  = '0;
            shreg_n = {rxd_s, shreg[D_W-1:1]};
            if (bit_cnt == DATA_LAST) begin
              bit_n   = '0;
              state_n = (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              bit_n = bit_cnt + BW'(1);
            end
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end
      end
      S_PAR: begin
        if (s_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_n    = '0;
            par_err_n = (PARITY == 1) ? ~par_x : par_x;
            state_n   = S_STOP;
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end
      end
      S_STOP: begin
        if (s_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_n    = '0;
            frm_err_n = stop_fe;
            if (bit_cnt == STOP_LAST) begin
              frame_done = 1'b1;
              frame_fe   = stop_fe;
              state_n    = stop_fe ? S_WAIT_IDLE : S_IDLE;
            end else begin
              bit_n = bit_cnt + BW'(1);
            end
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end
      end
      // A broken frame parks here until the line returns high.
      S_WAIT_IDLE: begin
        if (rxd_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Handshake: a word transfers on any clk where out_valid && out_ready; out_valid and the
  // data/flags stay stable until then. A completed frame may load in the same clk that the
  // held word is accepted; otherwise it is dropped and overrun pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data    <= '0;
      out_valid   <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      overrun <= frame_done && out_valid && !out_ready;
      if (frame_done && (!out_valid || out_ready)) begin
        out_data    <= shreg;
        parity_err  <= (PARITY != 0) ? par_err_q : 1'b0;
        framing_err <= frame_fe;
        out_valid   <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: an 8N1 instance and an 8E2 instance driven with serial frames,
// checked against expected frames computed from the bit stream sent.
module tb_uart_rx_core;

  localparam int D_W    = 8;
  localparam int B_TICK = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_tick = 1'b0;
  logic rxd0 = 1'b1, rxd1 = 1'b1;
  logic out_ready0 = 1'b1, out_ready1 = 1'b1;
  logic [D_W-1:0] out_data0, out_data1;
  logic out_valid0, out_valid1, pe0, pe1, fe0, fe1, ovr0, ovr1, busy0, busy1;

  int n_cmp = 0;
  int n_err = 0;
  int tick_mode = 0;
  logic [D_W+1:0] exp_q0[$];
  logic [D_W+1:0] exp_q1[$];
  int ovr_cnt0 = 0, ovr_cnt1 = 0, exp_ovr0 = 0, exp_ovr1 = 0;
  int hs_cnt0 = 0, hs_cnt1 = 0;
  bit busy_seen0 = 0;

  uart_rx_core #(.D_W(D_W), .B_TICK(B_TICK), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .rxd(rxd0),
    .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0),
    .parity_err(pe0), .framing_err(fe0), .overrun(ovr0), .busy(busy0)
  );

  uart_rx_core #(.D_W(D_W), .B_TICK(B_TICK), .PARITY(2), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .rxd(rxd1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .parity_err(pe1), .framing_err(fe1), .overrun(ovr1), .busy(busy1)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tick_mode == 0) s_tick = 1'b1;
      else s_tick = ($urandom_range(0, tick_mode) == 0);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted word must match the oldest expected frame.
  always @(negedge clk) begin
    if (!rst) begin
      if (ovr0) ovr_cnt0++;
      if (ovr1) ovr_cnt1++;
      if (busy0) busy_seen0 = 1;
      if (out_valid0 && out_ready0) begin
        hs_cnt0++;
        check_eq("frame_pending0", 32'(exp_q0.size() > 0), 1);
        if (exp_q0.size() > 0) begin
          logic [D_W+1:0] e;
          e = exp_q0.pop_front();
          check_eq("data0", out_data0, e[D_W-1:0]);
          check_eq("parity_err0", pe0, e[D_W]);
          check_eq("framing_err0", fe0, e[D_W+1]);
        end
      end
      if (out_valid1 && out_ready1) begin
        hs_cnt1++;
        check_eq("frame_pending1", 32'(exp_q1.size() > 0), 1);
        if (exp_q1.size() > 0) begin
          logic [D_W+1:0] e;
          e = exp_q1.pop_front();
          check_eq("data1", out_data1, e[D_W-1:0]);
          check_eq("parity_err1", pe1, e[D_W]);
          check_eq("framing_err1", fe1, e[D_W+1]);
        end
      end
    end
  end

  task automatic wait_ticks(input int n);
    int c = 0;
    while (c < n) begin
      @(posedge clk);
      if (s_tick) c++;
    end
  endtask

  task automatic send_bit(input int inst, input logic b);
    #1;
    if (inst == 0) rxd0 = b;
    else rxd1 = b;
    wait_ticks(B_TICK);
  endtask

  // inst 0 is 8N1, inst 1 is 8E2; hold_low extends the line low after the stop bits.
  task automatic send_frame(input int inst, input logic [D_W-1:0] d, input logic pbit,
                            input logic st0, input logic st1, input int hold_low);
    logic [D_W+1:0] e;
    int ones;
    ones = int'(pbit);
    for (int i = 0; i < D_W; i++) ones += int'(d[i]);
    if (inst == 0) begin
      e = {~st0, 1'b0, d};
      if (!out_ready0 && exp_q0.size() > 0) exp_ovr0++;
      else exp_q0.push_back(e);
    end else begin
      e = {~(st0 & st1), ones[0], d};
      if (!out_ready1 && exp_q1.size() > 0) exp_ovr1++;
      else exp_q1.push_back(e);
    end
    send_bit(inst, 1'b0);
    for (int i = 0; i < D_W; i++) send_bit(inst, d[i]);
    if (inst == 1) send_bit(inst, pbit);
    send_bit(inst, st0);
    if (inst == 1) send_bit(inst, st1);
    for (int i = 0; i < hold_low; i++) send_bit(inst, 1'b0);
    send_bit(inst, 1'b1);
  endtask

  task automatic wait_drain(input int inst);
    for (int i = 0; i < 2000 && ((inst == 0) ? exp_q0.size() : exp_q1.size()) > 0; i++)
      @(posedge clk);
    check_eq(inst == 0 ? "drain0" : "drain1", (inst == 0) ? exp_q0.size() : exp_q1.size(), 0);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_valid0", out_valid0, 0);
    check_eq("rst_data0", out_data0, 0);
    check_eq("rst_pe0", pe0, 0);
    check_eq("rst_fe0", fe0, 0);
    check_eq("rst_ovr0", ovr0, 0);
    check_eq("rst_busy0", busy0, 0);
    check_eq("rst_valid1", out_valid1, 0);
    check_eq("rst_busy1", busy1, 0);
  endtask

  initial begin
    int h, o;
    logic [D_W-1:0] pd;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;

    // 8N1 0xA5 with a tick every clk
    send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1, 0);
    wait_drain(0);
    check_eq("no_ovr_a5", ovr_cnt0, 0);

    // even parity: wrong then correct parity bit
    send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1, 0);
    send_frame(1, 8'h03, 1'b0, 1'b1, 1'b1, 0);
    wait_drain(1);

    // bad stop bit followed by a long break, then a clean frame
    h = hs_cnt0;
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 40);
    wait_drain(0);
    check_eq("break_one_frame", hs_cnt0 - h, 1);
    send_frame(0, 8'h55, 1'b0, 1'b1, 1'b1, 0);
    wait_drain(0);

    // short start glitch
    busy_seen0 = 0;
    h = hs_cnt0;
    #1 rxd0 = 1'b0;
    wait_ticks(5);
    #1 rxd0 = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_eq("glitch_busy_seen", busy_seen0, 1);
    check_eq("glitch_idle", busy0, 0);
    check_eq("glitch_no_frame", hs_cnt0 - h, 0);
    send_frame(0, 8'h81, 1'b0, 1'b1, 1'b1, 0);
    wait_drain(0);

    // overrun: consumer stalled across two frames
    out_ready0 = 1'b0;
    o = ovr_cnt0;
    send_frame(0, 8'h11, 1'b0, 1'b1, 1'b1, 0);
    send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1, 0);
    check_eq("ovr_once", ovr_cnt0 - o, 1);
    check_eq("held_valid", out_valid0, 1);
    check_eq("held_data", out_data0, 8'h11);
    h = hs_cnt0;
    #1 out_ready0 = 1'b1;
    wait_drain(0);
    @(posedge clk);
    #1;
    check_eq("ovr_one_hs", hs_cnt0 - h, 1);
    check_eq("ovr_valid_clr", out_valid0, 0);

    // reset during data bit 3 with a held word pending
    out_ready0 = 1'b0;
    send_frame(0, 8'h77, 1'b0, 1'b1, 1'b1, 0);
    pd = 8'h99;
    send_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(0, pd[i]);
    #1 rxd0 = pd[3];
    wait_ticks(B_TICK / 2);
    #1 rst = 1'b1;
    rxd0 = 1'b1;
    exp_q0.delete();
    @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;
    out_ready0 = 1'b1;
    wait_ticks(8 * B_TICK);
    #1;
    check_eq("no_partial_frame", out_valid0, 0);
    send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b1, 0);
    wait_drain(0);

    // randomized frames with sparse ticks
    tick_mode = 2;
    for (int n = 0; n < 12; n++) begin
      send_frame(0, 8'($urandom_range(0, 255)), 1'b0, ($urandom_range(0, 4) != 0), 1'b1, 0);
      wait_drain(0);
    end
    for (int n = 0; n < 12; n++) begin
      send_frame(1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0), 0);
      wait_drain(1);
    end

    check_eq("ovr_total0", ovr_cnt0, exp_ovr0);
    check_eq("ovr_total1", ovr_cnt1, exp_ovr1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
